// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit feeder.
package i2s_pkg;
  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  localparam int AUDIO_DW_DEF = 32;
  localparam int UCNT_W       = 16;
endpackage

// File: rtl/i2s_tx_feeder_if.sv
// Upstream stereo-pair stream: valid/ready handshake plus left/right samples.
interface i2s_tx_feeder_if #(
  parameter int AUDIO_DW = i2s_pkg::AUDIO_DW_DEF
);
  logic                in_valid;
  logic                in_ready;
  logic [AUDIO_DW-1:0] in_left;
  logic [AUDIO_DW-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input  in_ready);
  modport slave  (input  in_valid, input  in_left, input  in_right, output in_ready);
endinterface

// File: rtl/i2s_sync_fifo.sv
// Single-clock FIFO of stereo pairs with occupancy output; head is read combinationally.
module i2s_sync_fifo #(
  parameter int DW = 64,
  parameter int AW = 3
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  // Full is judged on the pre-pop level, so a pop never frees a slot in the same cycle.
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & (level_q != '0) & ~clr;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge sclk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/i2s_tx_feeder.sv
// Buffers upstream stereo pairs and presents one pair per lrclk frame to an i2s_tx,
// with prefill-gated start/restart and underrun reporting.
module i2s_tx_feeder
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW   = AUDIO_DW_DEF,
  parameter int DEPTH_LOG2 = 3,
  parameter int PREFILL    = 4,
  parameter int CNT_W      = UCNT_W
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  lrclk,
  input  logic                  flush,
  i2s_tx_feeder_if.slave        up,
  output logic [AUDIO_DW-1:0]   left_chan,
  output logic [AUDIO_DW-1:0]   right_chan,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underrun,
  output logic [CNT_W-1:0]      underrun_cnt
);
  state_t                state_q, state_d;
  logic                  lr_q;
  logic                  fall;
  logic                  pop;
  logic                  full;
  logic [2*AUDIO_DW-1:0] head;
  logic [AUDIO_DW-1:0]   left_q, left_d;
  logic [AUDIO_DW-1:0]   right_q, right_d;
  logic                  underrun_q, underrun_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign fall        = lr_q & ~lrclk;
  assign up.in_ready = ~full;

  i2s_sync_fifo #(
    .DW (2*AUDIO_DW),
    .AW (DEPTH_LOG2)
  ) u_fifo (
    .sclk  (sclk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (up.in_valid),
    .pop   (pop),
    .wdata ({up.in_left, up.in_right}),
    .rdata (head),
    .level (level),
    .full  (full)
  );

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    right_d    = right_q;
    underrun_d = 1'b0;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    if (flush) begin
      state_d = FILL;
      left_d  = '0;
      right_d = '0;
    end else if (fall) begin
      case (state_q)
        FILL: begin
          if (level >= (DEPTH_LOG2+1)'(PREFILL)) begin
            pop     = 1'b1;
            left_d  = head[2*AUDIO_DW-1:AUDIO_DW];
            right_d = head[AUDIO_DW-1:0];
            state_d = RUN;
          end
        end
        RUN: begin
          if (level != '0) begin
            pop     = 1'b1;
            left_d  = head[2*AUDIO_DW-1:AUDIO_DW];
            right_d = head[AUDIO_DW-1:0];
          end else begin
            // A missed frame sends silence and forces a fresh prefill before resuming.
            left_d     = '0;
            right_d    = '0;
            underrun_d = 1'b1;
            cnt_d      = cnt_q + CNT_W'(cnt_q != '1);
            state_d    = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      lr_q       <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lr_q       <= lrclk;
      left_q     <= left_d;
      right_q    <= right_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

  assign left_chan    = left_q;
  assign right_chan   = right_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = cnt_q;
endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Directed bench for i2s_tx_feeder: prefill, ordering, underrun, full, flush, reset, saturation.
module tb_i2s_tx_feeder;
  logic        sclk = 1'b0;
  logic        rst_n;
  logic        lrclk, lrclk_s;
  logic        flush;
  logic [31:0] left_chan, right_chan, left_s, right_s;
  logic [3:0]  level, level_s;
  logic        underrun, underrun_s;
  logic [15:0] underrun_cnt;
  logic [2:0]  cnt_s;
  int          n_cmp = 0;
  int          n_err = 0;

  i2s_tx_feeder_if #(.AUDIO_DW(32)) up ();
  i2s_tx_feeder_if #(.AUDIO_DW(32)) up_s ();

  always #5 sclk = ~sclk;

  i2s_tx_feeder #(.AUDIO_DW(32), .DEPTH_LOG2(3), .PREFILL(4)) dut (
    .sclk(sclk), .rst_n(rst_n), .lrclk(lrclk), .flush(flush), .up(up.slave),
    .left_chan(left_chan), .right_chan(right_chan), .level(level),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  // Narrow-counter, PREFILL=1 instance so counter saturation is reachable in few cycles.
  i2s_tx_feeder #(.AUDIO_DW(32), .DEPTH_LOG2(3), .PREFILL(1), .CNT_W(3)) dut_sat (
    .sclk(sclk), .rst_n(rst_n), .lrclk(lrclk_s), .flush(1'b0), .up(up_s.slave),
    .left_chan(left_s), .right_chan(right_s), .level(level_s),
    .underrun(underrun_s), .underrun_cnt(cnt_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] l, input logic [31:0] r,
                         input logic [3:0] lvl, input logic ur);
    chk({tag, ".left"}, left_chan, l);
    chk({tag, ".right"}, right_chan, r);
    chk({tag, ".level"}, level, lvl);
    chk({tag, ".underrun"}, underrun, ur);
  endtask

  task automatic push(input bit s, input logic [31:0] l, input logic [31:0] r);
    if (s) begin
      up_s.in_valid = 1'b1; up_s.in_left = l; up_s.in_right = r;
    end else begin
      up.in_valid = 1'b1; up.in_left = l; up.in_right = r;
    end
    @(negedge sclk);
    up.in_valid   = 1'b0;
    up_s.in_valid = 1'b0;
  endtask

  // lrclk high for hi cycles, then low; returns one cycle after the fall was seen.
  task automatic frame(input bit s, input int hi);
    if (s) lrclk_s = 1'b1; else lrclk = 1'b1;
    repeat (hi) @(negedge sclk);
    if (s) lrclk_s = 1'b0; else lrclk = 1'b0;
    @(negedge sclk);
  endtask

  initial begin
    rst_n = 1'b0; lrclk = 1'b0; lrclk_s = 1'b0; flush = 1'b0;
    up.in_valid = 1'b0; up.in_left = '0; up.in_right = '0;
    up_s.in_valid = 1'b0; up_s.in_left = '0; up_s.in_right = '0;
    repeat (3) @(negedge sclk);
    chk_out("reset", 32'h0, 32'h0, 4'd0, 1'b0);
    chk("reset.in_ready", up.in_ready, 1'b1);
    chk("reset.cnt", underrun_cnt, 16'd0);
    rst_n = 1'b1;

    // Prefill: nothing leaves until four pairs are stored
    frame(0, 32);
    chk_out("fill_empty", 32'h0, 32'h0, 4'd0, 1'b0);
    push(0, 32'h11111111, 32'h22222222);
    push(0, 32'h22222222, 32'h33333333);
    push(0, 32'h33333333, 32'h44444444);
    frame(0, 32);
    chk_out("fill_3", 32'h0, 32'h0, 4'd3, 1'b0);
    push(0, 32'h44444444, 32'h55555555);
    chk("fill_4.level", level, 4'd4);
    frame(0, 32);
    chk_out("pop1", 32'h11111111, 32'h22222222, 4'd3, 1'b0);
    frame(0, 32);
    chk_out("pop2", 32'h22222222, 32'h33333333, 4'd2, 1'b0);
    frame(0, 32);
    chk_out("pop3", 32'h33333333, 32'h44444444, 4'd1, 1'b0);
    frame(0, 32);
    chk_out("pop4", 32'h44444444, 32'h55555555, 4'd0, 1'b0);

    // Starvation in RUN
    frame(0, 32);
    chk_out("starve", 32'h0, 32'h0, 4'd0, 1'b1);
    chk("starve.cnt", underrun_cnt, 16'd1);
    @(negedge sclk);
    chk("starve.pulse_end", underrun, 1'b0);
    push(0, 32'h55555555, 32'h66666666);
    push(0, 32'h66666666, 32'h77777777);
    push(0, 32'h77777777, 32'h88888888);
    frame(0, 4);
    chk_out("refill_3", 32'h0, 32'h0, 4'd3, 1'b0);
    push(0, 32'h88888888, 32'h99999999);
    frame(0, 4);
    chk_out("restart", 32'h55555555, 32'h66666666, 4'd3, 1'b0);
    frame(0, 2);
    frame(0, 2);
    frame(0, 2);
    chk_out("drain", 32'h88888888, 32'h99999999, 4'd0, 1'b0);

    // Push on the exact fall cycle with empty FIFO: no bypass
    lrclk = 1'b1;
    @(negedge sclk);
    lrclk = 1'b0;
    up.in_valid = 1'b1; up.in_left = 32'hAAAAAAAA; up.in_right = 32'hBBBBBBBB;
    @(negedge sclk);
    up.in_valid = 1'b0;
    chk_out("nobypass", 32'h0, 32'h0, 4'd1, 1'b1);
    chk("nobypass.cnt", underrun_cnt, 16'd2);

    // Fill to full with valid held high
    for (int i = 1; i <= 7; i++) begin
      up.in_valid = 1'b1; up.in_left = 32'hC0000000 + 32'(i); up.in_right = 32'hD0000000 + 32'(i);
      @(negedge sclk);
    end
    up.in_left = 32'hCCCCCCCC; up.in_right = 32'hDDDDDDDD;
    chk("full.level", level, 4'd8);
    chk("full.in_ready", up.in_ready, 1'b0);
    lrclk = 1'b1;
    @(negedge sclk);
    chk("full_hold.level", level, 4'd8);
    lrclk = 1'b0;
    @(negedge sclk);
    chk_out("full_pop", 32'hAAAAAAAA, 32'hBBBBBBBB, 4'd7, 1'b0);
    chk("full_pop.in_ready", up.in_ready, 1'b1);
    @(negedge sclk);
    up.in_valid = 1'b0;
    chk("refull.level", level, 4'd8);
    chk("refull.in_ready", up.in_ready, 1'b0);
    frame(0, 2);
    chk_out("order1", 32'hC0000001, 32'hD0000001, 4'd7, 1'b0);
    frame(0, 2);
    chk_out("order2", 32'hC0000002, 32'hD0000002, 4'd6, 1'b0);

    // Flush with level 6
    flush = 1'b1;
    @(negedge sclk);
    flush = 1'b0;
    chk_out("flush", 32'h0, 32'h0, 4'd0, 1'b0);
    chk("flush.cnt", underrun_cnt, 16'd2);
    chk("flush.in_ready", up.in_ready, 1'b1);
    push(0, 32'hE1E1E1E1, 32'hF1F1F1F1);
    push(0, 32'hE2E2E2E2, 32'hF2F2F2F2);
    push(0, 32'hE3E3E3E3, 32'hF3F3F3F3);
    frame(0, 2);
    chk_out("flush_fill", 32'h0, 32'h0, 4'd3, 1'b0);
    push(0, 32'hE4E4E4E4, 32'hF4F4F4F4);
    frame(0, 2);
    chk_out("post_flush", 32'hE1E1E1E1, 32'hF1F1F1F1, 4'd3, 1'b0);

    // Asynchronous reset in the right half-frame
    lrclk = 1'b1;
    @(negedge sclk);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 32'h0, 32'h0, 4'd0, 1'b0);
    chk("async_rst.cnt", underrun_cnt, 16'd0);
    @(negedge sclk);
    rst_n = 1'b1;
    push(0, 32'h0A0A0A0A, 32'h0B0B0B0B);
    push(0, 32'h1A1A1A1A, 32'h1B1B1B1B);
    push(0, 32'h2A2A2A2A, 32'h2B2B2B2B);
    push(0, 32'h3A3A3A3A, 32'h3B3B3B3B);
    chk_out("rst_quiet", 32'h0, 32'h0, 4'd4, 1'b0);
    lrclk = 1'b0;
    @(negedge sclk);
    chk_out("rst_first_fall", 32'h0A0A0A0A, 32'h0B0B0B0B, 4'd3, 1'b0);

    // Underrun counter saturation on the narrow instance
    for (int i = 1; i <= 10; i++) begin
      push(1, 32'h5A000000 + 32'(i), 32'h5B000000 + 32'(i));
      frame(1, 1);
      chk("sat.pop_left", left_s, 32'h5A000000 + 32'(i));
      frame(1, 1);
      chk("sat.underrun", underrun_s, 1'b1);
      chk("sat.cnt", cnt_s, (i > 7) ? 3'd7 : 3'(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
